// File: rtl/mem_stage.sv
// Memory stage: sequences single-outstanding loads/stores on the data bus, aligns byte
// lanes, formats load data and registers the MEM/WB payload.
package lsu_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} lsuop_t;
endpackage

package pipe_pkg;
  typedef struct packed {
    logic [31:0]      opr_res;
    logic [31:0]      opr_b;
    logic [4:0]       rd;
    logic [31:0]      pc4;
    logic             rf_en;
    logic             dm_en;
    logic [1:0]       wb_sel;
    lsu_pkg::lsuop_t  lsuop;
  } ex_stage_out_t;

  typedef struct packed {
    logic [31:0] opr_res;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        rf_en;
    logic [1:0]  wb_sel;
  } mem_stage_out_t;
endpackage

// state | meaning
// IDLE  | no bus transaction open; retires non-bus instrs and granted stores
// REQ   | request presented, waiting for dbus_gnt
// WAIT  | load granted, waiting for dbus_rvalid
module mem_stage
  import lsu_pkg::*;
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  ex_stage_out_t         mem_stage_in,
  input  logic                  in_valid,
  output logic                  stall_o,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output mem_stage_out_t        mem_stage_out,
  output logic                  out_valid,
  output logic                  misaligned
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]     state_q, state_d;
  mem_stage_out_t out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           misaligned_q, misaligned_d;

  logic [1:0]  off;
  logic        is_store, is_half, is_word, misal, access;
  logic        retire, load_done;
  logic [31:0] lane_word, ld_data;

  always_comb begin
    off      = mem_stage_in.opr_res[1:0];
    is_store = mem_stage_in.lsuop inside {SB, SH, SW};
    is_half  = mem_stage_in.lsuop inside {LH, LHU, SH};
    is_word  = mem_stage_in.lsuop inside {LW, SW};
    misal    = mem_stage_in.dm_en & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    access   = in_valid & mem_stage_in.dm_en & ~misal;

    dbus_we    = is_store;
    dbus_addr  = ADDR_WIDTH'({mem_stage_in.opr_res[31:2], 2'b00});
    dbus_be    = is_word ? 4'b1111 : (is_half ? (4'b0011 << off) : (4'b0001 << off));
    dbus_wdata = DATA_WIDTH'(is_word ? mem_stage_in.opr_b :
                             (is_half ? {2{mem_stage_in.opr_b[15:0]}} : {4{mem_stage_in.opr_b[7:0]}}));

    // Shifting by the byte offset lands the addressed byte/half in the low lanes.
    lane_word = dbus_rdata[31:0] >> {off, 3'b000};
    case (mem_stage_in.lsuop)
      LB:      ld_data = {{24{lane_word[7]}}, lane_word[7:0]};
      LBU:     ld_data = {24'd0, lane_word[7:0]};
      LH:      ld_data = {{16{lane_word[15]}}, lane_word[15:0]};
      LHU:     ld_data = {16'd0, lane_word[15:0]};
      default: ld_data = dbus_rdata[31:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    load_done = 1'b0;
    stall_o   = 1'b0;
    dbus_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        retire = in_valid & ~access;
        if (access) begin
          dbus_req = 1'b1;
          if (!dbus_gnt) begin
            state_d = S_REQ;
            stall_o = 1'b1;
          end else if (is_store) begin
            retire = 1'b1;
          end else begin
            state_d = S_WAIT;
            stall_o = 1'b1;
          end
        end
      end
      S_REQ: begin
        dbus_req = 1'b1;
        stall_o  = 1'b1;
        if (dbus_gnt) begin
          if (is_store) begin
            state_d = S_IDLE;
            stall_o = 1'b0;
            retire  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_o = ~dbus_rvalid;
        if (dbus_rvalid) begin
          state_d   = S_IDLE;
          retire    = 1'b1;
          load_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) dbus_req = 1'b0;
  end

  always_comb begin
    out_d.opr_res = mem_stage_in.opr_res;
    out_d.rdata   = load_done ? ld_data : 32'd0;
    out_d.rd      = mem_stage_in.rd;
    out_d.pc4     = mem_stage_in.pc4;
    out_d.rf_en   = retire & mem_stage_in.rf_en & ~misal;
    out_d.wb_sel  = mem_stage_in.wb_sel;
    out_valid_d   = retire;
    misaligned_d  = retire & misal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_stage_out = out_q;
  assign out_valid     = out_valid_q;
  assign misaligned    = misaligned_q;
endmodule
